// File: rtl/slim_pkg.sv
// Shared types and constants for the slime enemy controller.
package slim_pkg;

    typedef enum logic [1:0] {
        WALK_L = 2'd0,
        WALK_R = 2'd1,
        FROZEN = 2'd2
    } slim_state_t;

    localparam int SPR_W   = 34;
    localparam int SPR_H   = 33;
    localparam int FRZ_HI  = 6;
    localparam int FRZ_MID = 3;

endpackage

// File: rtl/slim_addr_gen.sv
// Frame-latched sprite position and two-stage sprite ROM address pipeline.
module slim_addr_gen
    import slim_pkg::*;
#(
    parameter int X_INIT = 300,
    parameter int Y_INIT = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [13:0] slim,
    output logic        slim_vld
);

    logic [9:0]  shadow_x, shadow_y;
    logic [10:0] dx, dy;
    logic        in_win;
    logic [10:0] dx_s1, dy_s1;
    logic        in_s1;
    logic [13:0] addr;

    // Position only moves at the frame origin so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_x <= 10'(X_INIT);
            shadow_y <= 10'(Y_INIT);
        end else if (hcnt == 10'd0 && vcnt == 10'd0) begin
            shadow_x <= x;
            shadow_y <= y;
        end
    end

    always_comb begin
        dx     = {1'b0, hcnt} - {1'b0, shadow_x};
        dy     = {1'b0, vcnt} - {1'b0, shadow_y};
        in_win = !dx[10] && (dx < 11'(SPR_W)) && !dy[10] && (dy < 11'(SPR_H));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_s1 <= '0;
            dy_s1 <= '0;
            in_s1 <= 1'b0;
        end else begin
            dx_s1 <= dx;
            dy_s1 <= dy;
            in_s1 <= in_win;
        end
    end

    // Offsets are bounded by the window test, so 6 bits of each suffice.
    always_comb begin
        addr = 14'(dy_s1[5:0]) * 14'(SPR_W) + 14'(dx_s1[5:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slim     <= '0;
            slim_vld <= 1'b0;
        end else begin
            slim     <= in_s1 ? addr : 14'd0;
            slim_vld <= in_s1;
        end
    end

endmodule

// File: rtl/slim_ctrl.sv
// Slime enemy controller: walk/freeze FSM, position, freeze timer, address gen.
//
// state  | meaning
// WALK_L | moving left STEP pixels per tick until the left bound
// WALK_R | moving right STEP pixels per tick until the right bound
// FROZEN | stationary, frz_cnt counts ticks down, then resume_dir restored
module slim_ctrl
    import slim_pkg::*;
#(
    parameter int X_INIT       = 300,
    parameter int Y_INIT       = 400,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 606,
    parameter int STEP         = 2,
    parameter int FREEZE_TICKS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        freeze_hit,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    output logic [13:0] slim,
    output logic        slim_vld,
    output logic        slim_dir,
    output logic [1:0]  frz_lvl,
    output logic [9:0]  slim_x,
    output logic [9:0]  slim_y
);

    localparam logic [9:0] X_LO_EDGE = 10'(X_MIN + STEP);
    localparam logic [9:0] X_HI_EDGE = 10'(X_MAX - STEP);
    localparam logic [9:0] X_MIN_V   = 10'(X_MIN);
    localparam logic [9:0] X_MAX_V   = 10'(X_MAX);
    localparam logic [9:0] STEP_V    = 10'(STEP);
    localparam logic [3:0] FRZ_LOAD  = 4'(FREEZE_TICKS);

    slim_state_t state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q;
    logic [3:0]  frz_cnt_q, frz_cnt_d;
    logic        resume_dir_q, resume_dir_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WALK_L;
            x_q          <= 10'(X_INIT);
            y_q          <= 10'(Y_INIT);
            frz_cnt_q    <= '0;
            resume_dir_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            frz_cnt_q    <= frz_cnt_d;
            resume_dir_q <= resume_dir_d;
        end
    end

    // A hit always takes priority over a tick in the same cycle.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        frz_cnt_d    = frz_cnt_q;
        resume_dir_d = resume_dir_q;
        case (state_q)
            WALK_L: begin
                if (freeze_hit) begin
                    state_d      = FROZEN;
                    frz_cnt_d    = FRZ_LOAD;
                    resume_dir_d = 1'b0;
                end else if (tick) begin
                    if (x_q <= X_LO_EDGE) begin
                        x_d     = X_MIN_V;
                        state_d = WALK_R;
                    end else begin
                        x_d = x_q - STEP_V;
                    end
                end
            end
            WALK_R: begin
                if (freeze_hit) begin
                    state_d      = FROZEN;
                    frz_cnt_d    = FRZ_LOAD;
                    resume_dir_d = 1'b1;
                end else if (tick) begin
                    if (x_q >= X_HI_EDGE) begin
                        x_d     = X_MAX_V;
                        state_d = WALK_L;
                    end else begin
                        x_d = x_q + STEP_V;
                    end
                end
            end
            FROZEN: begin
                if (freeze_hit) begin
                    frz_cnt_d = FRZ_LOAD;
                end else if (tick) begin
                    frz_cnt_d = frz_cnt_q - 4'd1;
                    if (frz_cnt_q <= 4'd1) begin
                        frz_cnt_d = 4'd0;
                        state_d   = resume_dir_q ? WALK_R : WALK_L;
                    end
                end
            end
            default: begin
                state_d   = WALK_L;
                frz_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frz_lvl  <= 2'd0;
            slim_dir <= 1'b0;
        end else begin
            slim_dir <= (state_q == WALK_R) || (state_q == FROZEN && resume_dir_q);
            if (state_q != FROZEN)                frz_lvl <= 2'd0;
            else if (frz_cnt_q > 4'(FRZ_HI))      frz_lvl <= 2'd3;
            else if (frz_cnt_q > 4'(FRZ_MID))     frz_lvl <= 2'd2;
            else if (frz_cnt_q >= 4'd1)           frz_lvl <= 2'd1;
            else                                  frz_lvl <= 2'd0;
        end
    end

    assign slim_x = x_q;
    assign slim_y = y_q;

    slim_addr_gen #(
        .X_INIT (X_INIT),
        .Y_INIT (Y_INIT)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .x        (x_q),
        .y        (y_q),
        .slim     (slim),
        .slim_vld (slim_vld)
    );

endmodule

// File: tb/tb_slim_ctrl.sv
// Directed self-checking bench for slim_ctrl.
module tb_slim_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        freeze_hit = 1'b0;
    logic [9:0]  hcnt = '0;
    logic [9:0]  vcnt = '0;
    logic [13:0] slim;
    logic        slim_vld;
    logic        slim_dir;
    logic [1:0]  frz_lvl;
    logic [9:0]  slim_x;
    logic [9:0]  slim_y;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    slim_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .freeze_hit (freeze_hit),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .slim       (slim),
        .slim_vld   (slim_vld),
        .slim_dir   (slim_dir),
        .frz_lvl    (frz_lvl),
        .slim_x     (slim_x),
        .slim_y     (slim_y)
    );

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        tick = 1'b0;
        freeze_hit = 1'b0;
        hcnt = '0;
        vcnt = '0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            idle(1);
            tick = 1'b0;
            idle(1);
        end
    endtask

    task automatic hit(input logic with_tick);
        freeze_hit = 1'b1;
        tick = with_tick;
        idle(1);
        freeze_hit = 1'b0;
        tick = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        do_reset();
        idle(3);
        total++; if (slim_x !== 10'd300) begin bad++; $display("FAIL reset_x got=%0d exp=300", slim_x); end
        total++; if (slim_y !== 10'd400) begin bad++; $display("FAIL reset_y got=%0d exp=400", slim_y); end
        total++; if (slim_dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%0d exp=0", slim_dir); end
        total++; if (frz_lvl !== 2'd0) begin bad++; $display("FAIL reset_frz got=%0d exp=0", frz_lvl); end
        total++; if (slim_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0d exp=0", slim_vld); end
        total++; if (slim !== 14'd0) begin bad++; $display("FAIL reset_slim got=%0d exp=0", slim); end
    endtask

    task automatic test_walk();
        do_reset();
        ticks(10);
        total++; if (slim_x !== 10'd280) begin bad++; $display("FAIL walk10 got=%0d exp=280", slim_x); end
        ticks(139);
        total++; if (slim_x !== 10'd2) begin bad++; $display("FAIL walk_to2 got=%0d exp=2", slim_x); end
        total++; if (slim_dir !== 1'b0) begin bad++; $display("FAIL walk_dir_l got=%0d exp=0", slim_dir); end
        ticks(1);
        total++; if (slim_x !== 10'd0) begin bad++; $display("FAIL left_edge_x got=%0d exp=0", slim_x); end
        total++; if (slim_dir !== 1'b1) begin bad++; $display("FAIL left_edge_dir got=%0d exp=1", slim_dir); end
        ticks(1);
        total++; if (slim_x !== 10'd2) begin bad++; $display("FAIL turn_right_x got=%0d exp=2", slim_x); end
        ticks(300);
        total++; if (slim_x !== 10'd602) begin bad++; $display("FAIL walk_to602 got=%0d exp=602", slim_x); end
        ticks(2);
        total++; if (slim_x !== 10'd606) begin bad++; $display("FAIL right_edge_x got=%0d exp=606", slim_x); end
        total++; if (slim_dir !== 1'b0) begin bad++; $display("FAIL right_edge_dir got=%0d exp=0", slim_dir); end
        ticks(1);
        total++; if (slim_x !== 10'd604) begin bad++; $display("FAIL turn_left_x got=%0d exp=604", slim_x); end
    endtask

    task automatic test_freeze();
        do_reset();
        ticks(10);
        hit(1'b0);
        total++; if (frz_lvl !== 2'd3) begin bad++; $display("FAIL frz_entry got=%0d exp=3", frz_lvl); end
        ticks(3);
        total++; if (frz_lvl !== 2'd2) begin bad++; $display("FAIL frz_3t got=%0d exp=2", frz_lvl); end
        ticks(3);
        total++; if (frz_lvl !== 2'd1) begin bad++; $display("FAIL frz_6t got=%0d exp=1", frz_lvl); end
        total++; if (slim_x !== 10'd280) begin bad++; $display("FAIL frz_hold_x got=%0d exp=280", slim_x); end
        ticks(2);
        total++; if (frz_lvl !== 2'd1) begin bad++; $display("FAIL frz_8t got=%0d exp=1", frz_lvl); end
        ticks(1);
        total++; if (frz_lvl !== 2'd0) begin bad++; $display("FAIL frz_thaw got=%0d exp=0", frz_lvl); end
        total++; if (slim_dir !== 1'b0) begin bad++; $display("FAIL frz_thaw_dir got=%0d exp=0", slim_dir); end
        total++; if (slim_x !== 10'd280) begin bad++; $display("FAIL thaw_no_move got=%0d exp=280", slim_x); end
        ticks(1);
        total++; if (slim_x !== 10'd278) begin bad++; $display("FAIL after_thaw got=%0d exp=278", slim_x); end
    endtask

    task automatic test_hit_priority();
        do_reset();
        ticks(10);
        hit(1'b1);
        total++; if (slim_x !== 10'd280) begin bad++; $display("FAIL hit_tick_x got=%0d exp=280", slim_x); end
        total++; if (frz_lvl !== 2'd3) begin bad++; $display("FAIL hit_tick_frz got=%0d exp=3", frz_lvl); end
        ticks(5);
        total++; if (frz_lvl !== 2'd2) begin bad++; $display("FAIL rehit_pre got=%0d exp=2", frz_lvl); end
        hit(1'b0);
        total++; if (frz_lvl !== 2'd3) begin bad++; $display("FAIL rehit got=%0d exp=3", frz_lvl); end
        ticks(3);
        total++; if (frz_lvl !== 2'd2) begin bad++; $display("FAIL rehit_reload got=%0d exp=2", frz_lvl); end
    endtask

    task automatic test_right_freeze();
        do_reset();
        ticks(150);
        hit(1'b0);
        total++; if (slim_dir !== 1'b1) begin bad++; $display("FAIL frz_r_dir got=%0d exp=1", slim_dir); end
        ticks(9);
        total++; if (slim_dir !== 1'b1) begin bad++; $display("FAIL thaw_r_dir got=%0d exp=1", slim_dir); end
        ticks(1);
        total++; if (slim_x !== 10'd2) begin bad++; $display("FAIL thaw_r_x got=%0d exp=2", slim_x); end
    endtask

    task automatic probe(input logic [9:0] h, input logic [9:0] v,
                         input logic exp_vld, input logic [13:0] exp_addr,
                         input string name);
        hcnt = h;
        vcnt = v;
        idle(2);
        total++; if (slim_vld !== exp_vld) begin bad++; $display("FAIL %s vld got=%0d exp=%0d", name, slim_vld, exp_vld); end
        total++; if (slim !== exp_addr) begin bad++; $display("FAIL %s addr got=%0d exp=%0d", name, slim, exp_addr); end
    endtask

    task automatic test_addr();
        do_reset();
        hcnt = '0;
        vcnt = '0;
        idle(2);
        probe(10'd300, 10'd400, 1'b1, 14'd0,    "addr_origin");
        probe(10'd333, 10'd432, 1'b1, 14'd1121, "addr_max");
        probe(10'd334, 10'd400, 1'b0, 14'd0,    "addr_right_out");
        probe(10'd299, 10'd400, 1'b0, 14'd0,    "addr_left_out");
        probe(10'd305, 10'd402, 1'b1, 14'd73,   "addr_mid");
        probe(10'd300, 10'd433, 1'b0, 14'd0,    "addr_below");
        // position moves mid-frame; shadow must not follow until origin
        ticks(5);
        probe(10'd300, 10'd400, 1'b1, 14'd0,    "addr_no_tear");
        hcnt = '0;
        vcnt = '0;
        idle(2);
        probe(10'd300, 10'd400, 1'b1, 14'd10,   "addr_latched");
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        ticks(10);
        hit(1'b0);
        ticks(4);
        hcnt = '0;
        vcnt = '0;
        idle(2);
        hcnt = 10'd281;
        vcnt = 10'd401;
        idle(3);
        total++; if (slim_vld !== 1'b1) begin bad++; $display("FAIL pre_rst_vld got=%0d exp=1", slim_vld); end
        total++; if (frz_lvl !== 2'd2) begin bad++; $display("FAIL pre_rst_frz got=%0d exp=2", frz_lvl); end
        rst = 1'b1;
        idle(1);
        total++; if (slim_x !== 10'd300) begin bad++; $display("FAIL rst_x got=%0d exp=300", slim_x); end
        total++; if (frz_lvl !== 2'd0) begin bad++; $display("FAIL rst_frz got=%0d exp=0", frz_lvl); end
        total++; if (slim_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%0d exp=0", slim_vld); end
        total++; if (slim_dir !== 1'b0) begin bad++; $display("FAIL rst_dir got=%0d exp=0", slim_dir); end
        rst = 1'b0;
        idle(1);
        ticks(1);
        total++; if (slim_x !== 10'd298) begin bad++; $display("FAIL rst_walk_l got=%0d exp=298", slim_x); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_freeze();
        test_hit_priority();
        test_right_freeze();
        test_addr();
        test_reset_mid_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
